// File: rtl/alu_unit.sv
// alu_unit: 32-bit integer ALU (ADD/SUB/AND/ORR/EOR/MUL/UMULL/SMULL) with NZCV flags.
// Optional output register stage enabled by defining ALU_PIPE_EN; without it the
// unit is purely combinational and clk/reset are unused.
module alu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       ALUFlags
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_ORR   = 3'b011;
  localparam logic [2:0] OP_EOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_UMULL = 3'b110;
  localparam logic [2:0] OP_SMULL = 3'b111;

  logic                 is_sub;
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH:0]       sum;
  logic [DW-1:0]        prod_u;
  logic signed [DW-1:0] a_sx;
  logic signed [DW-1:0] b_sx;
  logic signed [DW-1:0] prod_s;

  logic [WIDTH-1:0]     res1_d;
  logic [WIDTH-1:0]     res2_d;
  logic [3:0]           flags_d;
  logic                 n_d;
  logic                 z_d;
  logic                 c_d;
  logic                 v_d;

  // Shared adder (SUB as a + ~b + 1) and both 64-bit multiplier flavours
  always_comb begin
    is_sub = (ALUControl == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    prod_s = a_sx * b_sx;
  end

  // Result select and NZCV generation
  always_comb begin
    res1_d = '0;
    res2_d = '0;
    c_d    = 1'b0;
    v_d    = 1'b0;
    unique case (ALUControl)
      OP_ADD, OP_SUB: begin
        res1_d = sum[WIDTH-1:0];
        c_d    = sum[WIDTH];
        v_d    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   res1_d = a & b;
      OP_ORR:   res1_d = a | b;
      OP_EOR:   res1_d = a ^ b;
      OP_MUL:   res1_d = prod_u[WIDTH-1:0];
      OP_UMULL: begin
        res1_d = prod_u[WIDTH-1:0];
        res2_d = prod_u[DW-1:WIDTH];
      end
      OP_SMULL: begin
        res1_d = prod_s[WIDTH-1:0];
        res2_d = prod_s[DW-1:WIDTH];
      end
      default: begin
        res1_d = '0;
        res2_d = '0;
      end
    endcase
    // Long multiplies report N/Z over the full 64-bit product
    if (ALUControl[2:1] == 2'b11) begin
      n_d = res2_d[WIDTH-1];
      z_d = ({res2_d, res1_d} == '0);
    end else begin
      n_d = res1_d[WIDTH-1];
      z_d = (res1_d == '0);
    end
    flags_d = {n_d, z_d, c_d, v_d};
  end

`ifdef ALU_PIPE_EN
  logic [WIDTH-1:0] res1_q;
  logic [WIDTH-1:0] res2_q;
  logic [3:0]       flags_q;

  // Output register stage, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res1_q  <= '0;
      res2_q  <= '0;
      flags_q <= '0;
    end else begin
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      flags_q <= flags_d;
    end
  end

  assign Result1  = res1_q;
  assign Result2  = res2_q;
  assign ALUFlags = flags_q;
`else
  // Clock and reset are kept on the port list for drop-in compatibility only
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, reset};

  assign Result1  = res1_d;
  assign Result2  = res2_d;
  assign ALUFlags = flags_d;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit (both ALU_PIPE_EN builds).
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ALUControl;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic [3:0]  ALUFlags;

  int unsigned pass_cnt;
  int unsigned chk_cnt;

  alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .Result1    (Result1),
    .Result2    (Result2),
    .ALUFlags   (ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Drive one operation and compare all three outputs
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] fl);
    ALUControl = op;
    a          = av;
    b          = bv;
`ifdef ALU_PIPE_EN
    @(posedge clk);
`endif
    #1;
    check({tag, ".r1"}, Result1, r1);
    check({tag, ".r2"}, Result2, r2);
    check({tag, ".fl"}, 32'(ALUFlags), 32'(fl));
  endtask

  initial begin
    pass_cnt   = 0;
    chk_cnt    = 0;
    reset      = 1'b0;
    a          = 32'h0;
    b          = 32'h0;
    ALUControl = 3'b000;

`ifdef ALU_PIPE_EN
    // Outputs held at zero while reset is low, even with live operands
    a = 32'h7FFFFFFF; b = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.r1", Result1, 32'h0);
    check("rst.r2", Result2, 32'h0);
    check("rst.fl", 32'(ALUFlags), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    a = 32'd2; b = 32'd3; ALUControl = 3'b000;
    #1;
    check("lat.before", Result1, 32'h0);
    @(posedge clk);
    #1;
    check("lat.after", Result1, 32'd5);
`else
    reset = 1'b1;
    #1;
`endif

    run_op("add_ovf",   3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'h9);
    run_op("add_carry", 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'h6);
    run_op("add_negov", 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 4'h7);
    run_op("add_small", 3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 4'h0);
    run_op("sub_eq",    3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 4'h6);
    run_op("sub_borr",  3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 4'h8);
    run_op("sub_ovf",   3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'h3);
    run_op("sub_neg",   3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 4'h8);
    run_op("and_zero",  3'b010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 32'h0, 4'h4);
    run_op("and_neg",   3'b010, 32'hFFFF0000, 32'hF0000000, 32'hF0000000, 32'h0, 4'h8);
    run_op("orr",       3'b011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0, 4'h8);
    run_op("eor",       3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'h0, 4'h4);
    run_op("eor_mix",   3'b100, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 32'h0, 4'h0);
    run_op("mul_wrap",  3'b101, 32'h00010000, 32'h00010000, 32'h00000000, 32'h0, 4'h4);
    run_op("mul_small", 3'b101, 32'h00000003, 32'h00000005, 32'h0000000F, 32'h0, 4'h0);
    run_op("mul_neg",   3'b101, 32'h80000000, 32'h00000001, 32'h80000000, 32'h0, 4'h8);
    run_op("mul_big",   3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0, 4'h0);
    run_op("umull_max", 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'h8);
    run_op("umull_hi",  3'b110, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001, 4'h0);
    run_op("umull_x2",  3'b110, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 4'h0);
    run_op("umull_z",   3'b110, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 4'h4);
    run_op("smull_m1",  3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'h0);
    run_op("smull_neg", 3'b111, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'h8);

`ifdef ALU_PIPE_EN
    // Reset asserted mid-run clears outputs without waiting for a clock edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst.r1", Result1, 32'h0);
    check("midrst.r2", Result2, 32'h0);
    check("midrst.fl", 32'(ALUFlags), 32'h0);
`else
    // Reset has no effect on the combinational build
    reset = 1'b0;
    run_op("rst_ignored", 3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 4'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the single-cycle/multicycle ARM-style datapath.
- Takes two operands and a 3-bit operation select.
- Produces a primary 32-bit result, a secondary 32-bit result (upper word of long multiplies), and NZCV condition flags.
- Datapath is combinational. The clock and reset are used only by the optional output register stage.

Parameters:
- WIDTH, 32, operand/result width. Only 32 needs to be supported; flag bit positions assume 32.

Ports:
- clk  input  1  system clock. Used only when ALU_PIPE_EN is defined.
- reset  input  1  asynchronous, active-low reset. Used only when ALU_PIPE_EN is defined.
- a  input  32  operand A.
- b  input  32  operand B.
- ALUControl  input  3  operation select.
- Result1  output  32  primary result (low word for long multiplies).
- Result2  output  32  secondary result (high word for long multiplies, else 0).
- ALUFlags  output  4  {N, Z, C, V}, bit3 = N, bit0 = V.

Behaviour:
- Default build: purely combinational. Outputs follow inputs with zero cycles of latency, settled within half a clock period.
- ALUControl encoding (Result1 / Result2):
  - 000 ADD: a + b / 0.
  - 001 SUB: a + ~b + 1 / 0.
  - 010 AND: a & b / 0.
  - 011 ORR: a | b / 0.
  - 100 EOR: a ^ b / 0.
  - 101 MUL: low 32 bits of a*b / 0.
  - 110 UMULL: {Result2, Result1} = unsigned 64-bit a*b.
  - 111 SMULL: {Result2, Result1} = signed two's-complement 64-bit a*b.
- N flag:
  - Result1[31] for ops 000-101.
  - Result2[31] for UMULL and SMULL.
- Z flag:
  - Result1 == 0 for ops 000-101.
  - {Result2, Result1} == 0 for UMULL and SMULL.
- C flag:
  - ADD and SUB: carry-out of the 33-bit sum. For SUB, C = 1 means no borrow (a >= b unsigned).
  - All other ops: 0.
- V flag:
  - ADD and SUB only: set when both adder inputs (a and the possibly inverted b) have equal sign bits and the sum sign differs.
  - All other ops: 0.
- ADD and SUB wrap modulo 2^32. No saturation.
- Any X on an input may propagate. No undefined ALUControl codes exist.

Optional Feature:
- Macro ALU_PIPE_EN.
- When defined:
  - Result1, Result2 and ALUFlags are registered on the rising edge of clk, giving 1-cycle latency.
  - reset low clears all three outputs to 0 asynchronously.
  - After reset deasserts, the register updates every cycle. There is no enable.
- When not defined:
  - Outputs are combinational as described above.
  - clk and reset are present but unused, and reset has no effect.

Test Plan:
- ADD a=7FFFFFFF b=00000001 -> Result1=80000000, Result2=0, ALUFlags=9 (N, V).
- SUB a=00000005 b=00000005 -> Result1=0, ALUFlags=6 (Z, C). SUB a=0 b=1 -> Result1=FFFFFFFF, ALUFlags=8.
- AND a=F0F0F0F0 b=0F0F0F0F -> Result1=0, ALUFlags=4. ORR on the same operands -> FFFFFFFF, ALUFlags=8. EOR a=b=A5A5A5A5 -> 0, ALUFlags=4.
- MUL a=00010000 b=00010000 -> Result1=0, Result2=0, ALUFlags=4. MUL a=3 b=5 -> Result1=F, ALUFlags=0.
- UMULL a=b=FFFFFFFF -> Result2=FFFFFFFE, Result1=00000001, ALUFlags=8. SMULL on the same operands -> Result2=0, Result1=1, ALUFlags=0.
- ALU_PIPE_EN defined:
  - Hold reset low -> all outputs 0.
  - Release reset, apply ADD 2+3 -> Result1=5 appears after the next rising edge, not before.
  - Assert reset mid-run -> outputs clear immediately.
